// File: rtl/wb_ipi_mailbox.sv
// Two-core inter-processor mailbox on Wishbone B3: per-core 32-bit message FIFOs, sticky overflow, and level interrupts.
// Every request terminates exactly one cycle after it is sampled; the bus never stalls, and a push to a full FIFO is dropped.

module wb_ipi_mailbox_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_vld_i,
  input  logic [31:0] push_dat_i,
  input  logic        pop_rdy_i,
  output logic [31:0] head_dat_o,
  output logic [3:0]  count_o,
  output logic        full_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [3:0]    count_q;
  logic          do_push, do_pop;

  assign full_o     = (count_q == 4'(DEPTH));
  assign do_push    = push_vld_i & ~full_o;
  assign do_pop     = pop_rdy_i & (count_q != 4'd0);
  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  // DEPTH is a power of two, so pointer wrap falls out of the natural overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 4'd0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 4'd1;
        2'b01:   count_q <= count_q - 4'd1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

module wb_ipi_mailbox #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic [2:0]  wb_cti_i,
  input  logic [1:0]  wb_bte_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o,
  output logic [1:0]  irq_o
);
  localparam logic [2:0] A_TX0 = 3'd0, A_TX1 = 3'd1, A_RX0 = 3'd2, A_RX1 = 3'd3;
  localparam logic [2:0] A_STATUS = 3'd4, A_IRQ_EN = 3'd5, A_OVF_CLR = 3'd6, A_NONE = 3'd7;

  logic        ack_q, ack_d, err_q, err_d;
  logic [31:0] dat_q, dat_d;
  logic [1:0]  en_q, en_d, ovf_q, ovf_d, irq_q, irq_d;

  logic        req_vld, wr_vld, rd_vld;
  logic [2:0]  idx;
  logic [1:0]  push_vld, pop_rdy, full, ovf_clr;
  logic [31:0] head_dat [2];
  logic [3:0]  count [2];
  logic        unused_ok;

  assign unused_ok = ^{wb_adr_i[31:5], wb_adr_i[1:0], wb_sel_i[3:1], wb_cti_i, wb_bte_i};

  assign idx     = wb_adr_i[4:2];
  assign req_vld = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
  assign wr_vld  = req_vld & wb_we_i;
  assign rd_vld  = req_vld & ~wb_we_i;

  assign push_vld[0] = wr_vld & (idx == A_TX0);
  assign push_vld[1] = wr_vld & (idx == A_TX1);
  assign pop_rdy[0]  = rd_vld & (idx == A_RX0);
  assign pop_rdy[1]  = rd_vld & (idx == A_RX1);

  for (genvar n = 0; n < 2; n++) begin : g_fifo
    wb_ipi_mailbox_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i      (wb_clk_i),
      .rst_ni     (wb_rst_ni),
      .push_vld_i (push_vld[n]),
      .push_dat_i (wb_dat_i),
      .pop_rdy_i  (pop_rdy[n]),
      .head_dat_o (head_dat[n]),
      .count_o    (count[n]),
      .full_o     (full[n])
    );
  end

  always_comb begin
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dat_d   = 32'h0;
    en_d    = en_q;
    ovf_clr = 2'b00;
    if (req_vld) begin
      ack_d = (idx != A_NONE);
      err_d = (idx == A_NONE);
      if (wb_we_i) begin
        if (idx == A_IRQ_EN && wb_sel_i[0]) en_d = wb_dat_i[1:0];
        if (idx == A_OVF_CLR) ovf_clr = wb_dat_i[1:0];
      end else begin
        case (idx)
          A_RX0:    dat_d = (count[0] != 4'd0) ? head_dat[0] : 32'h0;
          A_RX1:    dat_d = (count[1] != 4'd0) ? head_dat[1] : 32'h0;
          A_STATUS: dat_d = {22'h0, ovf_q, count[1], count[0]};
          A_IRQ_EN: dat_d = {30'h0, en_q};
          default:  dat_d = 32'h0;
        endcase
      end
    end
    // A same-edge overflow beats the clear.
    ovf_d = (ovf_q & ~ovf_clr) | (push_vld & full);
    irq_d = en_q & {count[1] != 4'd0, count[0] != 4'd0};
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= 32'h0;
      en_q  <= 2'b00;
      ovf_q <= 2'b00;
      irq_q <= 2'b00;
    end else begin
      ack_q <= ack_d;
      err_q <= err_d;
      dat_q <= dat_d;
      en_q  <= en_d;
      ovf_q <= ovf_d;
      irq_q <= irq_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_rty_o = 1'b0;
  assign wb_dat_o = dat_q;
  assign irq_o    = irq_q;
endmodule

// File: tb/tb_wb_ipi_mailbox.sv
// Directed bench for wb_ipi_mailbox: drives Wishbone accesses one step after the rising edge and checks against hand-computed values.
module tb_wb_ipi_mailbox;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] adr = '0, dat_w = '0;
  logic [3:0]  sel = 4'hF;
  logic        we = 1'b0, cyc = 1'b0, stb = 1'b0;
  logic [2:0]  cti = 3'b000;
  logic [1:0]  bte = 2'b00;
  logic [31:0] dat_r;
  logic        ack, err, rty;
  logic [1:0]  irq;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] TX0 = 32'h00, TX1 = 32'h04, RX0 = 32'h08, RX1 = 32'h0C;
  localparam logic [31:0] STATUS = 32'h10, IRQ_EN = 32'h14, OVF_CLR = 32'h18, BAD = 32'h1C;

  wb_ipi_mailbox #(.FIFO_DEPTH(4)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wb_adr_i  (adr),
    .wb_dat_i  (dat_w),
    .wb_sel_i  (sel),
    .wb_we_i   (we),
    .wb_cyc_i  (cyc),
    .wb_stb_i  (stb),
    .wb_cti_i  (cti),
    .wb_bte_i  (bte),
    .wb_dat_o  (dat_r),
    .wb_ack_o  (ack),
    .wb_err_o  (err),
    .wb_rty_o  (rty),
    .irq_o     (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called one step after a rising edge; returns one step after the edge following termination.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output logic a_o, output logic e_o);
    adr = a; we = w; dat_w = d; sel = s; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    a_o = ack; e_o = err; rd = dat_r;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    chk("term_one_cycle", {30'h0, ack, err}, 32'h0);
  endtask

  task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd;
    logic a_o, e_o;
    xfer(a, 1'b1, d, s, rd, a_o, e_o);
    chk(tag, {30'h0, a_o, e_o}, 32'h2);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    logic a_o, e_o;
    xfer(a, 1'b0, 32'h0, 4'hF, rd, a_o, e_o);
    chk({tag, "_ack"}, {30'h0, a_o, e_o}, 32'h2);
    chk(tag, rd, exp);
  endtask

  initial begin
    logic [31:0] rd;
    logic a_o, e_o;
    logic [3:0] pat;

    #2;
    chk("rst_ack_err_rty", {29'h0, ack, err, rty}, 32'h0);
    chk("rst_dat", dat_r, 32'h0);
    chk("rst_irq", {30'h0, irq}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single message to core 0 with interrupt enabled.
    wr("en_wr", IRQ_EN, 32'h1, 4'hF);
    adr = TX0; we = 1'b1; dat_w = 32'hA5A5_0001; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    #4;
    chk("tx0_no_early_ack", {31'h0, ack}, 32'h0);
    @(posedge clk); #1;
    chk("tx0_ack_n1", {30'h0, ack, err}, 32'h2);
    chk("irq_not_yet", {30'h0, irq}, 32'h0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    chk("irq0_set", {30'h0, irq}, 32'h1);
    rd_chk("rx0_data", RX0, 32'hA5A5_0001);
    chk("irq0_clear", {30'h0, irq}, 32'h0);

    // Overflow on FIFO1.
    for (int i = 1; i <= 5; i++) wr("tx1_wr", TX1, 32'(i), 4'hF);
    rd_chk("status_ovf1", STATUS, 32'h0000_0240);
    for (int i = 1; i <= 4; i++) rd_chk("rx1_order", RX1, 32'(i));
    rd_chk("rx1_empty", RX1, 32'h0);
    wr("ovf_clr", OVF_CLR, 32'h2, 4'hF);
    rd_chk("status_cleared", STATUS, 32'h0);

    rd_chk("rx0_empty", RX0, 32'h0);
    rd_chk("status_after_empty", STATUS, 32'h0);

    // Unmapped address.
    xfer(BAD, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, a_o, e_o);
    chk("bad_err", {30'h0, a_o, e_o}, 32'h1);
    chk("bad_dat", rd, 32'h0);
    rd_chk("status_after_bad", STATUS, 32'h0);
    rd_chk("en_after_bad", IRQ_EN, 32'h1);

    // Pointer wrap at depth 4.
    for (int i = 0; i < 3; i++) wr("wrap_push_a", TX0, 32'h10 + 32'(i), 4'hF);
    for (int i = 0; i < 3; i++) rd_chk("wrap_pop_a", RX0, 32'h10 + 32'(i));
    for (int i = 0; i < 3; i++) wr("wrap_push_b", TX0, 32'h13 + 32'(i), 4'hF);
    rd_chk("wrap_status", STATUS, 32'h3);
    for (int i = 0; i < 3; i++) rd_chk("wrap_pop_b", RX0, 32'h13 + 32'(i));

    // IRQ_EN byte-select gating; TX ignores byte selects.
    wr("en_sel0_off", IRQ_EN, 32'h3, 4'b1110);
    rd_chk("en_unchanged", IRQ_EN, 32'h1);
    wr("en_sel0_on", IRQ_EN, 32'h3, 4'b0001);
    rd_chk("en_both", IRQ_EN, 32'h3);
    wr("tx1_sel0", TX1, 32'hDEAD_BEEF, 4'b0000);
    chk("irq1_set", {30'h0, irq}, 32'h2);
    rd_chk("rx1_fullword", RX1, 32'hDEAD_BEEF);

    // Harmless accesses.
    rd_chk("tx0_read_zero", TX0, 32'h0);
    rd_chk("ovfclr_read_zero", OVF_CLR, 32'h0);
    wr("status_wr", STATUS, 32'hFFFF_FFFF, 4'hF);
    wr("rx0_wr", RX0, 32'hFFFF_FFFF, 4'hF);
    rd_chk("status_untouched", STATUS, 32'h0);

    // Held strobe: terminations every other cycle.
    adr = STATUS; we = 1'b0; cyc = 1'b1; stb = 1'b1; cti = 3'b010; bte = 2'b01;
    pat = 4'h0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      pat[i] = ack;
    end
    cyc = 1'b0; stb = 1'b0; cti = 3'b000; bte = 2'b00;
    chk("b2b_pattern", {28'h0, pat}, 32'h5);
    @(posedge clk); #1;

    // Reset in the middle of a pending request.
    wr("en_one", IRQ_EN, 32'h1, 4'hF);
    wr("pre_rst_push", TX0, 32'h77, 4'hF);
    wr("pre_rst_push", TX0, 32'h78, 4'hF);
    rd_chk("pre_rst_status", STATUS, 32'h2);
    chk("pre_rst_irq", {30'h0, irq}, 32'h1);
    adr = RX0; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_irq", {30'h0, irq}, 32'h0);
    @(posedge clk); #1;
    chk("rst_no_ack", {30'h0, ack, err}, 32'h0);
    chk("rst_dat_zero", dat_r, 32'h0);
    cyc = 1'b0; stb = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_no_ack", {30'h0, ack, err}, 32'h0);
    rd_chk("post_rst_status", STATUS, 32'h0);
    rd_chk("post_rst_en", IRQ_EN, 32'h0);
    rd_chk("post_rst_rx0", RX0, 32'h0);
    chk("post_rst_irq", {30'h0, irq}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
